// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // gnt is one-hot or zero; zero encodes to 0.
  function automatic logic [SEL_W-1:0] oh2bin(input logic [REQ_N-1:0] oh);
    logic [SEL_W-1:0] b;
    b = '0;
    for (int i = 0; i < REQ_N; i++)
      if (oh[i]) b = b | SEL_W'(i);
    return b;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first eligible requester at ptr, ptr+1, ... (mod 4).
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [REQ_N-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [REQ_N-1:0] elig;
  logic [SEL_W-1:0] cand;

  assign elig = req & ~excl;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = REQ_N-1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux with bounded tenure and back-to-back handover.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_N-1:0]   req,
  input  logic [REQ_N*W-1:0] a,
  output logic [REQ_N-1:0]   gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [W-1:0]       y,
  output logic               preempt
);

  localparam int               CNT_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] own;
  logic             own_req;
  logic             ten_end;
  logic [SEL_W-1:0] ho_ptr;
  logic [REQ_N-1:0] ho_excl;
  logic             idle_found, ho_found;
  logic [SEL_W-1:0] idle_idx, ho_idx;

  assign own     = oh2bin(gnt);
  assign own_req = req[own];
  // A tenure ends on release, or on timeout while still requested.
  assign ten_end = (state == ST_OWN) && (!own_req || (cnt == CNT_LAST));
  assign ho_ptr  = own + SEL_W'(1);
  assign ho_excl = REQ_N'(1) << own;

  rr_pick4 u_pick_idle (
    .req   (req),
    .ptr   (ptr),
    .excl  (REQ_N'(0)),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Handover search starts just past the owner and skips it.
  rr_pick4 u_pick_ho (
    .req   (req),
    .ptr   (ho_ptr),
    .excl  (ho_excl),
    .found (ho_found),
    .idx   (ho_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_found) begin
            state <= ST_OWN;
            gnt   <= REQ_N'(1) << idle_idx;
            sel   <= idle_idx;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_OWN: begin
          if (ten_end) begin
            ptr     <= ho_ptr;
            preempt <= own_req;
            cnt     <= '0;
            if (ho_found) begin
              gnt <= REQ_N'(1) << ho_idx;
              sel <= ho_idx;
            end else if (!own_req) begin
              state <= ST_IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
            // else: sole requester timed out and is re-granted in place
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign y = busy ? a[sel*W +: W] : '0;

endmodule
